// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/exec/wb control for the
// 8-bit datapath; owns pc, ir and the ALU/RF/SAR control strobes.
module alu_sequencer #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [7:0]    imem_data,
    input  logic          imem_valid,
    output logic [1:0]    alu_control,
    input  logic          alu_branch,
    output logic [1:0]    rf_addr,
    input  logic [7:0]    rf_rdata,
    output logic          rf_we,
    output logic          sar_we,
    output logic [1:0]    sar_sel,
    output logic [7:0]    imm,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] ir;
    logic [1:0] alu_q;
    logic       br_q;

    logic       ir_ld;
    logic       pc_clr;
    logic       pc_adv;

    logic       is_alu;
    logic       is_br;
    logic       is_movs;
    logic       is_halt;
    logic       is_movr;
    logic       is_li;
    logic       wr_sar;

    always_comb begin
        is_alu  = (ir[7:6] == 2'b00);
        is_br   = is_alu && (ir[5:4] == 2'b10);
        is_movs = (ir[7:5] == 3'b010);
        is_halt = (ir[7:5] == 3'b011);
        is_movr = (ir[7:6] == 2'b10);
        is_li   = (ir[7:6] == 2'b11);
        wr_sar  = (is_alu && !is_br) || is_movs || is_li;
    end

    always_comb begin
        sar_sel = 2'b00;
        unique case (1'b1)
            is_movs: sar_sel = 2'b01;
            is_li:   sar_sel = 2'b10;
            default: sar_sel = 2'b00;
        endcase
    end

    // Controls come straight from ir so they hold across DECODE..WB
    // and fall back to the reset pattern when ir is cleared.
    assign rf_addr     = ir[1:0];
    assign imm         = {2'b00, ir[5:0]};
    assign alu_control = alu_q;
    assign imem_addr   = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        sar_we   = 1'b0;
        rf_we    = 1'b0;
        ir_ld    = 1'b0;
        pc_clr   = 1'b0;
        pc_adv   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    pc_clr  = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_valid) begin
                    ir_ld   = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                busy    = 1'b1;
                state_n = S_EXEC;
            end
            S_EXEC: begin
                busy    = 1'b1;
                state_n = S_WB;
            end
            S_WB: begin
                busy   = 1'b1;
                sar_we = wr_sar;
                rf_we  = is_movr;
                if (is_halt) begin
                    state_n = S_HALT;
                end else begin
                    pc_adv  = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    pc_clr  = 1'b1;
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            ir    <= '0;
            alu_q <= 2'b00;
            br_q  <= 1'b0;
        end else begin
            if (ir_ld) begin
                ir <= imem_data;
                if (imem_data[7:6] == 2'b00) begin
                    alu_q <= imem_data[5:4];
                end
            end
            if (state == S_EXEC) begin
                br_q <= is_br && alu_branch;
            end
            if (pc_clr) begin
                pc <= '0;
            end else if (pc_adv) begin
                if (is_br && br_q) begin
                    pc <= AW'(rf_rdata);
                end else begin
                    pc <= pc + AW'(1);
                end
            end
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle instruction sequencer that drives the 8-bit datapath.
- Fetches 8-bit instructions over a request/valid handshake, decodes them, and drives the ALU control code.
- Samples the ALU branch flag and issues register-file and set-aside-register (SAR) write strobes.
- Owns the program counter.

Parameters:
- AW, 8, program counter / instruction address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  leave IDLE or HALT and begin at address 0.
- imem_req  output  1  fetch request.
- imem_addr  output  AW  fetch address; equals pc.
- imem_data  input  8  instruction; valid when imem_valid=1.
- imem_valid  input  1  fetch response strobe.
- alu_control  output  2  ALU operation: 00 add, 01 nand, 10 branch-test, 11 set-less-than.
- alu_branch  input  1  ALU branch flag.
- rf_addr  output  2  register-file read/write index.
- rf_rdata  input  8  register-file read data (branch target).
- rf_we  output  1  register-file write strobe (data = SAR).
- sar_we  output  1  SAR write strobe.
- sar_sel  output  2  SAR source: 00 ALU result, 01 rf_rdata, 10 imm.
- imm  output  8  zero-extended immediate.
- pc  output  AW  current program counter.
- busy  output  1  high in FETCH/DECODE/EXEC/WB.
- halted  output  1  high in HALT.

Behaviour:
- Reset (async, active-high): state=IDLE, pc=0, ir=0.
- Reset values of outputs:
  - imem_req=0, rf_we=0, sar_we=0, busy=0, halted=0.
  - alu_control=00, sar_sel=00, rf_addr=0, imm=0.
- Reset asserted mid-fetch or mid-instruction drops imem_req and all strobes immediately. No write completes.
- Instruction decode (ir):
  - ir[7:6]=00 ALU op: alu_control=ir[5:4], rf_addr=ir[1:0].
    - Funcs 00/01/11: SAR <- ALU result (sar_sel=00).
    - Func 10 (branch): no write. If alu_branch=1 is sampled in EXEC, pc <- rf_rdata[AW-1:0]; else pc <- pc+1.
  - ir[7:6]=01, ir[5]=0 MOVS: SAR <- R[ir[1:0]] (sar_sel=01).
  - ir[7:6]=01, ir[5]=1 HALT.
  - ir[7:6]=10 MOVR: R[ir[1:0]] <- SAR (rf_we).
  - ir[7:6]=11 LI: SAR <- {2'b00, ir[5:0]} (sar_sel=10).
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE: waits for start=1, then pc <- 0 and go to FETCH. busy=0.
  - FETCH: imem_req=1, imem_addr=pc, both held stable until imem_valid=1. In that cycle ir <- imem_data and go to DECODE. Wait is unbounded.
  - DECODE: one cycle. alu_control, rf_addr, sar_sel, imm driven from ir. These stay stable through EXEC and WB.
  - EXEC: one cycle. alu_branch is registered here (branch instructions only).
  - WB: one cycle.
    - sar_we or rf_we pulses high for exactly this cycle per the decode table; never both.
    - pc updated (pc+1 or branch target), then go to FETCH.
    - For HALT: no strobe, pc unchanged, go to HALT.
  - HALT: halted=1, busy=0. start=1 sets pc <- 0 and goes to FETCH.
- imem_valid is ignored whenever imem_req=0.
- start is ignored in FETCH/DECODE/EXEC/WB.
- Minimum instruction latency is 4 cycles (FETCH with same-cycle valid, DECODE, EXEC, WB).
- pc+1 wraps modulo 2^AW (2^AW-1 -> 0).
- Branch target uses the low AW bits of rf_rdata.
- alu_control outside DECODE/EXEC/WB holds its last value.
- alu_control is 00 after reset.

Test Plan:
- Reset/idle: assert reset mid-FETCH with imem_req=1 -> imem_req=0, pc=0, state IDLE same cycle. No strobes. Outputs stay idle until start.
- Straight-line: start, then program 11_000101 (LI 5), 10_0000_01 (MOVR R1), 00_00_00_01 (ADD R1), with imem_valid same-cycle.
  - sar_we pulses with sar_sel=10, imm=0x05.
  - rf_we pulses with rf_addr=1.
  - alu_control=00 held DECODE..WB, sar_we with sar_sel=00.
  - Each instruction takes 4 cycles; pc 0->1->2->3.
- Fetch stall: hold imem_valid=0 for 5 cycles at pc=3 -> imem_req and imem_addr=3 stable all 5 cycles. No ir change.
- Branch: ir=00_10_00_10, rf_rdata=0x40.
  - With alu_branch=1 in EXEC -> pc=0x40 after WB, no write strobes.
  - Repeat with alu_branch=0 -> pc=old pc+1.
- Wrap/halt:
  - Instruction at pc=0xFF non-branch -> next fetch at 0x00.
  - 01_100000 (HALT) at pc=7 -> halted=1, busy=0, pc stays 7.
  - start -> pc=0, FETCH, imem_req=1.
- Ignored inputs: start pulsed during EXEC -> no effect. imem_valid=1 during DECODE -> ir unchanged.
